m68k_bus_master: RTL

Bus-cycle sequencer that drives the 68000-side bus as master. It takes one read or write request at a time from the internal request interface and runs a standard 68000 asynchronous cycle (S0–S7) with unlimited-until-timeout wait states. Sequencing uses the MCCLK edge strobes and the DTACK latch pulse produced by the clock synchronizer. Everything runs in the SYSCLK domain; bus pins are driven from registers only.

---
 rtl/m68k_bus_master.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/m68k_bus_master.sv
// 68000 asynchronous bus-cycle master: runs one read/write request at a time through S0-S7,
// stepping on MCCLK edge strobes, with DTACK wait states and a timeout abort.
module m68k_bus_master #(
    parameter int WAIT_LIMIT = 64
) (
    input  logic        sysclk,
    input  logic        nreset,
    input  logic        mcclk_rising,
    input  logic        mcclk_falling,
    input  logic        dtack_latch,
    input  logic        req,
    input  logic        req_rw,
    input  logic [22:0] req_addr,
    input  logic        req_uds,
    input  logic        req_lds,
    input  logic [15:0] req_wdata,
    output logic        ack,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [22:0] bus_addr,
    output logic        bus_as_n,
    output logic        bus_uds_n,
    output logic        bus_lds_n,
    output logic        bus_rw,
    output logic [15:0] bus_dout,
    output logic        bus_doe,
    input  logic [15:0] bus_din,
    output logic [3:0]  dbg_state
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7
    } state_t;

    state_t          state;
    logic            rw_q;
    logic [22:0]     addr_q;
    logic            uds_q;
    logic            lds_q;
    logic [15:0]     wdata_q;
    logic            dtack_seen;
    logic [CW-1:0]   wait_cnt;

    assign dbg_state = state;

    always_ff @(negedge sysclk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            uds_q      <= 1'b0;
            lds_q      <= 1'b0;
            wdata_q    <= '0;
            dtack_seen <= 1'b0;
            wait_cnt   <= '0;
            ack        <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            bus_addr   <= '0;
            bus_as_n   <= 1'b1;
            bus_uds_n  <= 1'b1;
            bus_lds_n  <= 1'b1;
            bus_rw     <= 1'b1;
            bus_dout   <= '0;
            bus_doe    <= 1'b0;
        end else begin
            ack  <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;

            // DTACK only counts once the address strobe phase has begun.
            if (dtack_latch && (state == S2 || state == S3 || state == S4))
                dtack_seen <= 1'b1;

            case (state)
                IDLE: if (mcclk_rising && req) begin
                    state      <= S0;
                    ack        <= 1'b1;
                    busy       <= 1'b1;
                    rw_q       <= req_rw;
                    addr_q     <= req_addr;
                    uds_q      <= req_uds;
                    lds_q      <= req_lds;
                    wdata_q    <= req_wdata;
                    bus_rw     <= req_rw;
                    dtack_seen <= 1'b0;
                    wait_cnt   <= '0;
                end
                S0: if (mcclk_falling) begin
                    state    <= S1;
                    bus_addr <= addr_q;
                end
                S1: if (mcclk_rising) begin
                    state    <= S2;
                    bus_as_n <= 1'b0;
                    if (rw_q) begin
                        bus_uds_n <= ~uds_q;
                        bus_lds_n <= ~lds_q;
                    end
                end
                S2: if (mcclk_falling) begin
                    state <= S3;
                    if (!rw_q) begin
                        bus_dout <= wdata_q;
                        bus_doe  <= 1'b1;
                    end
                end
                S3: if (mcclk_rising) begin
                    state <= S4;
                    if (!rw_q) begin
                        bus_uds_n <= ~uds_q;
                        bus_lds_n <= ~lds_q;
                    end
                end
                S4: if (mcclk_falling) begin
                    if (dtack_seen || dtack_latch) begin
                        state <= S5;
                    end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                        // Timeout: terminate straight into S7 without sampling data.
                        state     <= S7;
                        wait_cnt  <= wait_cnt + 1'b1;
                        bus_as_n  <= 1'b1;
                        bus_uds_n <= 1'b1;
                        bus_lds_n <= 1'b1;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S5: if (mcclk_rising) state <= S6;
                S6: if (mcclk_falling) begin
                    state     <= S7;
                    if (rw_q) rdata <= bus_din;
                    bus_as_n  <= 1'b1;
                    bus_uds_n <= 1'b1;
                    bus_lds_n <= 1'b1;
                    done      <= 1'b1;
                end
                S7: if (mcclk_rising) begin
                    state   <= IDLE;
                    bus_doe <= 1'b0;
                    bus_rw  <= 1'b1;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
